// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with optional first-word-fall-through,
// almost-full/empty thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 56,
    parameter int AEMPTY_TH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C    = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C   = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] CNT_ZERO_C = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE_C  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO_C = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE_C  = ADDR_W'(1);

    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH) || (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)
        || (FWFT < 0) || (FWFT > 1)) begin : g_bad_param
        $error("sync_fifo_param: illegal FWFT/AFULL_TH/AEMPTY_TH for depth %0d", DEPTH);
    end

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_s;
    logic              full_r;
    logic              empty_r;
    logic              afull_r;
    logic              aempty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ovf_set_s;
    logic              unf_set_s;

    // Acceptance is judged on registered flags; flush blocks both requests and the error sets.
    always_comb begin
        wr_acc_s  = wr_en && !full_r && !flush;
        rd_acc_s  = rd_en && !empty_r && !flush;
        ovf_set_s = wr_en && full_r && !flush;
        unf_set_s = rd_en && empty_r && !flush;
        if (flush) begin
            count_s = CNT_ZERO_C;
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_s = count_r + CNT_ONE_C;
                2'b01:   count_s = count_r - CNT_ONE_C;
                default: count_s = count_r;
            endcase
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and flags registered from the next count so they move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= PTR_ZERO_C;
                rd_ptr_r <= PTR_ZERO_C;
            end else begin
                if (wr_acc_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (rd_acc_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            count_r  <= count_s;
            full_r   <= (count_s == DEPTH_C);
            empty_r  <= (count_s == CNT_ZERO_C);
            afull_r  <= (count_s >= AFULL_C);
            aempty_r <= (count_s <= AEMPTY_C);
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (unf_set_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; it is meaningless while empty.
        assign rd_data  = mem_r[rd_ptr_r];
        assign rd_valid = !empty_r;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_r;
        logic              rd_valid_r;

        // Registered read port: one-cycle latency, data holds between reads and across flush.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_r  <= {DATA_W{1'b0}};
                rd_valid_r <= 1'b0;
            end else if (flush) begin
                rd_data_r  <= rd_data_r;
                rd_valid_r <= 1'b0;
            end else if (rd_acc_s) begin
                rd_data_r  <= mem_r[rd_ptr_r];
                rd_valid_r <= 1'b1;
            end else begin
                rd_data_r  <= rd_data_r;
                rd_valid_r <= 1'b0;
            end
        end

        assign rd_data  = rd_data_r;
        assign rd_valid = rd_valid_r;
    end

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus stream
// and are compared against a queue-based model, a vector table and directed corner sequences.
module tb_sync_fifo_param;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] d0_rd_data, d1_rd_data;
    logic       d0_rd_valid, d1_rd_valid, d0_full, d1_full, d0_empty, d1_empty;
    logic       d0_af, d1_af, d0_ae, d1_ae, d0_ovf, d1_ovf, d0_unf, d1_unf;
    logic [2:0] d0_count, d1_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_rv0 = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count), .clr_err(clr_err),
        .overflow(d0_ovf), .underflow(d0_unf));

    sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count), .clr_err(clr_err),
        .overflow(d1_ovf), .underflow(d1_unf));

    typedef struct {
        logic       fl, wr;
        logic [7:0] wd;
        logic       rd, clr;
        int         e_count;
        logic       e_full, e_empty, e_af, e_ae, e_rv;
        logic [7:0] e_rd;
        logic       e_ovf, e_unf;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic f, input logic w, input logic [7:0] d, input logic r,
                          input logic c);
        flush = f; wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rv0 = 1'b0; m_rd0 = 8'h00;
    endtask

    // Queue semantics: space and data availability judged on pre-edge occupancy.
    task automatic model_edge();
        int  sz;
        logic ovs, uns;
        sz = q.size();
        ovs = 1'b0; uns = 1'b0;
        if (flush) begin
            q.delete();
            m_rv0 = 1'b0;
        end else begin
            ovs = wr_en && (sz == D);
            uns = rd_en && (sz == 0);
            if (rd_en && sz > 0) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1'b1;
            end else begin
                m_rv0 = 1'b0;
            end
            if (wr_en && sz < D) q.push_back(wr_data);
        end
        if (ovs) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
        if (uns) m_unf = 1'b1; else if (clr_err) m_unf = 1'b0;
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count",      32'(d0_count),    32'(sz));
        chk("full",       32'(d0_full),     32'(sz == D));
        chk("empty",      32'(d0_empty),    32'(sz == 0));
        chk("afull",      32'(d0_af),       32'(sz >= AF));
        chk("aempty",     32'(d0_ae),       32'(sz <= AE));
        chk("overflow",   32'(d0_ovf),      32'(m_ovf));
        chk("underflow",  32'(d0_unf),      32'(m_unf));
        chk("std_valid",  32'(d0_rd_valid), 32'(m_rv0));
        chk("std_data",   32'(d0_rd_data),  32'(m_rd0));
        chk("fw_count",   32'(d1_count),    32'(sz));
        chk("fw_flags",   32'({d1_full, d1_empty, d1_af, d1_ae}),
            32'({sz == D, sz == 0, sz >= AF, sz <= AE}));
        chk("fw_err",     32'({d1_ovf, d1_unf}), 32'({m_ovf, m_unf}));
        chk("fw_valid",   32'(d1_rd_valid), 32'(sz != 0));
        if (sz > 0) chk("fw_head", 32'(d1_rd_data), 32'(q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        // Tests 1 and 2: fill to overflow, then drain to underflow on the standard port.
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(d0_count), 32'd0);
        chk("rst_flags", 32'({d0_full, d0_empty, d0_af, d0_ae}), 32'b0101);
        chk("rst_data",  32'({d0_rd_valid, d0_rd_data}), 32'h000);
        chk("rst_err",   32'({d0_ovf, d0_unf, d1_ovf, d1_unf}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].fl, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            step();
            chk("t_count", 32'(d0_count), 32'(tbl[i].e_count));
            chk("t_flags", 32'({d0_full, d0_empty, d0_af, d0_ae}),
                32'({tbl[i].e_full, tbl[i].e_empty, tbl[i].e_af, tbl[i].e_ae}));
            chk("t_rd", 32'({d0_rd_valid, d0_rd_data}), 32'({tbl[i].e_rv, tbl[i].e_rd}));
            chk("t_err", 32'({d0_ovf, d0_unf}), 32'({tbl[i].e_ovf, tbl[i].e_unf}));
        end

        // Test 3: steady count of 2 with simultaneous write/read across pointer wraps.
        set_in(1'b0, 1'b1, 8'hB0, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0); step();
        for (int k = 0; k < 10; k++) begin
            logic [7:0] exp_d;
            exp_d = (k == 0) ? 8'hB0 : (k == 1) ? 8'hB1 : 8'(8'hC0 + k - 2);
            set_in(1'b0, 1'b1, 8'(8'hC0 + k), 1'b1, 1'b0);
            step();
            chk("wrap_count", 32'(d0_count), 32'd2);
            chk("wrap_data", 32'({d0_rd_valid, d0_rd_data}), 32'({1'b1, exp_d}));
            chk("wrap_flags", 32'({d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf}), 32'd0);
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step(); step();

        // Test 4: FWFT head appears with no read; count==1 read+write returns the old head.
        set_in(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fw_show", 32'({d1_rd_valid, d1_rd_data}), 32'h1A5);
        step();
        chk("fw_hold", 32'({d1_rd_valid, d1_rd_data}), 32'h1A5);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        chk("fw_pop", 32'({d1_empty, d1_rd_valid}), 32'b10);
        set_in(1'b0, 1'b1, 8'h61, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 8'h62, 1'b1, 1'b0); step();
        chk("rw1_std", 32'(d0_rd_data), 32'h61);
        chk("rw1_fw", 32'({d1_count, d1_rd_data}), 32'({3'd1, 8'h62}));
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();

        // Test 5: flush beats a same-cycle write; a fresh underflow beats clr_err.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b1, 8'(8'h71 + k), 1'b0, 1'b0); step();
        end
        set_in(1'b1, 1'b1, 8'h74, 1'b0, 1'b0); step();
        chk("flush", 32'({d0_count, d0_empty, d0_ovf, d0_rd_valid}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        chk("flush_hold", 32'(d0_rd_data), 32'h62);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); step();
        chk("set_wins", 32'(d0_unf), 32'd1);
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
        chk("clr_err", 32'(d0_unf), 32'd0);

        // Test 6: asynchronous reset mid-burst, then a clean write/read.
        set_in(1'b0, 1'b1, 8'h81, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 8'h82, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 8'h83, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count", 32'({d0_count, d1_count}), 32'd0);
        chk("arst_flags", 32'({d0_full, d0_empty, d0_af, d0_ae, d1_rd_valid}), 32'b01010);
        chk("arst_data", 32'({d0_rd_valid, d0_rd_data}), 32'h000);
        set_in(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("post_fw", 32'(d1_rd_data), 32'h5A);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
        chk("post_std", 32'(d0_rd_data), 32'h5A);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic f;
            f = ($urandom_range(0, 24) == 0);
            set_in(f, ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                   !f && ($urandom_range(0, 15) == 0));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
